app_tst_seq: RTL and testbench
==============================

# app_tst_seq

Parametrised power-up test sequencer and per-channel run gate for the SGDMA application layer. It succeeds the single-channel test controller. After reset it runs an init delay and asserts NUM_STG sticky stage enables at evenly spaced, maskable times. It also gates NUM_CH pairs of H2C/C2H run requests against per-channel loopback mode, holding a quiesce window after every mode change. It sits between the user-side mode/run sources and the register-test, loopback and DMA traffic generators.

## Interface
- NUM_STG, 4: number of stage enables (≥1)
- NUM_CH, 2: number of DMA channel pairs (≥1)
- CNT_W, 12: init counter width
- INIT_DLY, 4010: init length in cycles; requires 1 ≤ INIT_DLY ≤ 2^CNT_W
- STG_BASE, 100: counter value that fires stage 0
- STG_GAP, 1000: counter spacing between stages; requires STG_BASE+(NUM_STG-1)*STG_GAP < INIT_DLY (elaboration check)
- QUIESCE, 8: gate cycles after a loopback-mode change; 0 disables quiescing
- usr_clk  in  1  single clock
- usr_rst_n  in  1  asynchronous, active-low reset
- restart_i  in  1  single-cycle pulse that restarts the sequence
- stg_mask_i  in  NUM_STG  per-stage enable mask; bit k is sampled only at stage k's fire edge
- lp_md_i  in  2*NUM_CH  per-channel mode; channel c is in loopback when bits [2c+1:2c] are 2'b11
- h2c_run_i  in  NUM_CH  H2C run requests
- c2h_run_i  in  NUM_CH  C2H run requests
- stg_run_o  out  NUM_STG  sticky stage enables
- init_done_o  out  1  init delay complete, sticky until restart
- lp_run_o  out  NUM_CH  registered loopback run
- h2c_run_o  out  NUM_CH  gated H2C run
- c2h_run_o  out  NUM_CH  gated C2H run

## Operation
- Reset value of every output is 0. Counter resets to 0; FSM resets to S_INIT.
- FSM S_INIT:
  - The counter increments on every edge.
  - On the edge where cnt == T_k = STG_BASE + k*STG_GAP, stg_run_o[k] is set to stg_mask_i[k].
  - On the edge where cnt == INIT_DLY-1: cnt ← 0, init_done_o ← 1, go to S_DONE.
- FSM S_DONE: the counter holds at 0 and stage outputs hold.
- restart_i in either state clears stg_run_o, init_done_o and cnt on that edge and goes to (or stays in) S_INIT. Restart takes priority over the stage fire and the done edge in the same cycle.
- Per channel c:
  - lp_run_o[c] ← &lp_md_i[2c+1:2c]
  - h2c_run_o[c] ← h2c_run_i[c] & ~lp_run_o[c] & (qcnt[c]==0) & gate
  - c2h_run_o[c] uses the same formula with c2h_run_i[c].
  - gate = 1, except as described under Configuration.
- Quiesce counter qcnt[c], width $clog2(QUIESCE+1):
  - On an edge where the next lp_run_o[c] differs from its current value, load QUIESCE.
  - Otherwise decrement while nonzero.
  - A toggle while qcnt is nonzero reloads it. There is no underflow.
- Channels are fully independent and are not affected by restart_i.

## Timing
- Stage k is first visible high after T_k+1 edges from reset release; init_done_o after INIT_DLY edges.
- Restart pulse at edge r: outputs low after edge r; stage k high again after edge r+T_k+1.
- lp_run_o latency: 1 cycle from lp_md_i.
- h2c/c2h latency: 1 cycle from run input when the channel is not in loopback and not quiescing.
- Entering loopback: md → 11 sampled at edge e means lp_run_o is high after edge e, and h2c/c2h_run_o drop after edge e+1.
- Leaving loopback (lp_run_o falls at edge e): h2c/c2h_run_o can first rise after edge e+QUIESCE+1.
- Inputs are assumed synchronous to usr_clk; there is no internal synchroniser.

## Configuration
- APP_TST_INIT_GATE_EN:
  - Defined: gate = init_done_o, so h2c/c2h_run_o stay 0 until the init delay completes and again after every restart until it completes.
  - Undefined: gate = 1, and channel gating ignores the sequencer.

## Structure
- Shared package app_tst_pkg holds:
  - the FSM state typedef (S_INIT, S_DONE)
  - default INIT_DLY / STG_BASE / STG_GAP / QUIESCE constants
  - a function computing T_k
- Sub-module app_tst_ch: one channel's lp_run register, quiesce counter and H2C/C2H gating. It is instantiated NUM_CH times in a generate loop; the top holds the FSM, counter and stage logic.

## Test plan
- Reset release with defaults, mask 4'hF → stg_run_o bits rise after edges 101, 1101, 2101, 3101; init_done_o after edge 4010; cnt holds 0 thereafter.
- Mask 4'b0101 held only around T_1 → stg_run_o[1] stays 0, others rise on schedule; mask changes after T_k have no effect.
- restart_i at cycle 2500 → all stage outputs and init_done_o clear next edge; stage 0 re-rises 101 edges after restart; restart coinciding with cnt==T_2 leaves stage 2 low.
- Channel 0 md 00→11 with h2c_run_i=1 → lp_run_o[0] high 1 cycle later, h2c_run_o[0] low 2 cycles after md change; channel 1 output unaffected.
- md 11→00 with QUIESCE=8 → h2c/c2h_run_o[0] return high exactly 9 edges after lp_run_o falls; md toggled again at quiesce count 3 reloads to 8.
- With APP_TST_INIT_GATE_EN, c2h_run_i=1 from reset → c2h_run_o low until 1 cycle after init_done_o rises; without the macro, high after the first edge.

Source files
------------

// File: rtl/app_tst_pkg.sv
`default_nettype none
// ============================================================================
// app_tst_pkg : shared state type, default timing and stage-time helper
// Rev 1.0
// ============================================================================
package app_tst_pkg;

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_DONE = 1'b1
  } state_t;

  localparam int c_init_dly = 4010;
  localparam int c_stg_base = 100;
  localparam int c_stg_gap  = 1000;
  localparam int c_quiesce  = 8;

  // Counter value on which stage k fires
  function automatic int stg_time(input int base, input int gap, input int k);
    return base + k * gap;
  endfunction

endpackage
`default_nettype wire

// File: rtl/app_tst_seq_if.sv
`default_nettype none
// ============================================================================
// app_tst_seq_if : user-side mode/run inputs and sequencer/gated run outputs
// Rev 1.0
// ============================================================================
interface app_tst_seq_if #(
  parameter int NUM_STG = 4,
  parameter int NUM_CH  = 2
);
  logic                  restart_i;
  logic [NUM_STG-1:0]    stg_mask_i;
  logic [2*NUM_CH-1:0]   lp_md_i;
  logic [NUM_CH-1:0]     h2c_run_i;
  logic [NUM_CH-1:0]     c2h_run_i;
  logic [NUM_STG-1:0]    stg_run_o;
  logic                  init_done_o;
  logic [NUM_CH-1:0]     lp_run_o;
  logic [NUM_CH-1:0]     h2c_run_o;
  logic [NUM_CH-1:0]     c2h_run_o;

  modport master (
    output restart_i, stg_mask_i, lp_md_i, h2c_run_i, c2h_run_i,
    input  stg_run_o, init_done_o, lp_run_o, h2c_run_o, c2h_run_o
  );

  modport slave (
    input  restart_i, stg_mask_i, lp_md_i, h2c_run_i, c2h_run_i,
    output stg_run_o, init_done_o, lp_run_o, h2c_run_o, c2h_run_o
  );
endinterface
`default_nettype wire

// File: rtl/app_tst_ch.sv
`default_nettype none
// ============================================================================
// app_tst_ch : one channel's loopback register, quiesce counter and run gating
// Rev 1.0
// ============================================================================
module app_tst_ch
  import app_tst_pkg::*;
#(
  parameter int QUIESCE = c_quiesce
) (
  input  wire        usr_clk,
  input  wire        usr_rst_n,
  input  wire [1:0]  lp_md_i,
  input  wire        h2c_run_i,
  input  wire        c2h_run_i,
  input  wire        gate_i,
  output logic       lp_run_o,
  output logic       h2c_run_o,
  output logic       c2h_run_o
);

  localparam int              c_qw    = (QUIESCE > 0) ? $clog2(QUIESCE + 1) : 1;
  localparam logic [c_qw-1:0] c_qload = c_qw'(QUIESCE);

  logic [c_qw-1:0] r_qcnt;
  logic            r_lp;
  logic            r_h2c;
  logic            r_c2h;
  logic            w_lp_nxt;
  logic            w_open;

  assign w_lp_nxt = &lp_md_i;
  // Runs see the registered mode, so entering loopback drops them one edge later
  assign w_open   = ~r_lp & (r_qcnt == '0) & gate_i;

  always_ff @(posedge usr_clk or negedge usr_rst_n) begin
    if (!usr_rst_n) begin
      r_lp   <= 1'b0;
      r_qcnt <= '0;
      r_h2c  <= 1'b0;
      r_c2h  <= 1'b0;
    end else begin
      r_lp  <= w_lp_nxt;
      r_h2c <= h2c_run_i & w_open;
      r_c2h <= c2h_run_i & w_open;
      if (w_lp_nxt != r_lp) begin
        r_qcnt <= c_qload;
      end else if (r_qcnt != '0) begin
        r_qcnt <= r_qcnt - 1'b1;
      end
    end
  end

  assign lp_run_o  = r_lp;
  assign h2c_run_o = r_h2c;
  assign c2h_run_o = r_c2h;

endmodule
`default_nettype wire

// File: rtl/app_tst_seq.sv
`default_nettype none
// ============================================================================
// app_tst_seq : power-up stage sequencer with per-channel loopback run gating
// Option: APP_TST_INIT_GATE_EN holds channel runs off until init_done_o
// Rev 1.0
// ============================================================================
module app_tst_seq
  import app_tst_pkg::*;
#(
  parameter int NUM_STG  = 4,
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 12,
  parameter int INIT_DLY = c_init_dly,
  parameter int STG_BASE = c_stg_base,
  parameter int STG_GAP  = c_stg_gap,
  parameter int QUIESCE  = c_quiesce
) (
  input  wire           usr_clk,
  input  wire           usr_rst_n,
  app_tst_seq_if.slave  bus
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(INIT_DLY - 1);

  if ((INIT_DLY < 1) || (INIT_DLY > (1 << CNT_W)) ||
      (stg_time(STG_BASE, STG_GAP, NUM_STG - 1) >= INIT_DLY)) begin : g_cfg_err
    $error("app_tst_seq: stage times or INIT_DLY out of range");
  end

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_STG-1:0] r_stg;
  logic               r_done;
  logic [NUM_STG-1:0] w_fire;
  logic               w_gate;
  logic [NUM_CH-1:0]  w_lp;
  logic [NUM_CH-1:0]  w_h2c;
  logic [NUM_CH-1:0]  w_c2h;

  for (genvar k = 0; k < NUM_STG; k++) begin : g_stg
    localparam logic [CNT_W-1:0] c_tk = CNT_W'(stg_time(STG_BASE, STG_GAP, k));
    assign w_fire[k] = (r_cnt == c_tk);
  end

  // Restart outranks both the stage fire and the done edge
  always_ff @(posedge usr_clk or negedge usr_rst_n) begin
    if (!usr_rst_n) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
      r_stg   <= '0;
      r_done  <= 1'b0;
    end else if (bus.restart_i) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
      r_stg   <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_stg <= (r_stg & ~w_fire) | (bus.stg_mask_i & w_fire);
          if (r_cnt == c_last) begin
            r_cnt   <= '0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

`ifdef APP_TST_INIT_GATE_EN
  assign w_gate = r_done;
`else
  assign w_gate = 1'b1;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    app_tst_ch #(
      .QUIESCE (QUIESCE)
    ) u_ch (
      .usr_clk   (usr_clk),
      .usr_rst_n (usr_rst_n),
      .lp_md_i   (bus.lp_md_i[2*c+1:2*c]),
      .h2c_run_i (bus.h2c_run_i[c]),
      .c2h_run_i (bus.c2h_run_i[c]),
      .gate_i    (w_gate),
      .lp_run_o  (w_lp[c]),
      .h2c_run_o (w_h2c[c]),
      .c2h_run_o (w_c2h[c])
    );
  end

  assign bus.stg_run_o   = r_stg;
  assign bus.init_done_o = r_done;
  assign bus.lp_run_o    = w_lp;
  assign bus.h2c_run_o   = w_h2c;
  assign bus.c2h_run_o   = w_c2h;

endmodule
`default_nettype wire

// File: tb/tb_app_tst_seq.sv
`default_nettype none
// ============================================================================
// tb_app_tst_seq : directed stimulus with a cycle-stamped expectation scoreboard
// Rev 1.0
// ============================================================================
module tb_app_tst_seq;

`ifdef APP_TST_INIT_GATE_EN
  localparam bit c_gated = 1'b1;
`else
  localparam bit c_gated = 1'b0;
`endif

  localparam int c_stg = 0, c_done = 1, c_lp = 2, c_h2c = 3, c_c2h = 4;

  typedef struct {
    int         cyc;
    int         sel;
    logic [7:0] exp;
    string      name;
  } exp_t;

  logic usr_clk   = 1'b0;
  logic usr_rst_n = 1'b0;
  int   cyc       = 0;
  int   n_tests   = 0;
  int   n_fail    = 0;
  bit   done_stim = 1'b0;
  exp_t sb[$];

  app_tst_seq_if #(.NUM_STG(4), .NUM_CH(2)) bus ();

  app_tst_seq dut (
    .usr_clk   (usr_clk),
    .usr_rst_n (usr_rst_n),
    .bus       (bus)
  );

  always #5 usr_clk = ~usr_clk;

  always @(posedge usr_clk) if (usr_rst_n) cyc <= cyc + 1;

  function automatic logic [7:0] get_sig(input int sel);
    logic [7:0] v;
    v = '0;
    case (sel)
      c_stg:   v[3:0] = bus.stg_run_o;
      c_done:  v[0]   = bus.init_done_o;
      c_lp:    v[1:0] = bus.lp_run_o;
      c_h2c:   v[1:0] = bus.h2c_run_o;
      default: v[1:0] = bus.c2h_run_o;
    endcase
    return v;
  endfunction

  task automatic expect_at(input int c, input int sel, input logic [7:0] v, input string nm);
    exp_t e;
    e.cyc  = c;
    e.sel  = sel;
    e.exp  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge usr_clk);
  endtask

  // Monitor: compare every expectation stamped with the current cycle
  always @(negedge usr_clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (done_stim) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s never checked (cyc %0d)", sb[i].name, sb[i].cyc);
        sb.delete(i);
      end else if (sb[i].cyc == cyc) begin
        logic [7:0] act;
        act = get_sig(sb[i].sel);
        n_tests++;
        if (act !== sb[i].exp) begin
          n_fail++;
          $display("FAIL %s @cyc %0d: got %h expected %h", sb[i].name, cyc, act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    bus.restart_i  = 1'b0;
    bus.stg_mask_i = 4'hF;
    bus.lp_md_i    = 4'b0000;
    bus.h2c_run_i  = 2'b11;
    bus.c2h_run_i  = 2'b01;

    expect_at(0, c_stg,  8'h0, "rst_stg");
    expect_at(0, c_done, 8'h0, "rst_done");
    expect_at(0, c_lp,   8'h0, "rst_lp");
    expect_at(0, c_h2c,  8'h0, "rst_h2c");
    expect_at(0, c_c2h,  8'h0, "rst_c2h");
    expect_at(1, c_h2c,  c_gated ? 8'h0 : 8'h3, "first_h2c");
    expect_at(1, c_c2h,  c_gated ? 8'h0 : 8'h1, "first_c2h");
    expect_at(100,  c_stg, 8'h0, "s0_pre");
    expect_at(101,  c_stg, 8'h1, "s0_rise");
    expect_at(1100, c_stg, 8'h1, "s1_pre");
    expect_at(1101, c_stg, 8'h3, "s1_rise");
    expect_at(2100, c_stg, 8'h3, "s2_pre");
    expect_at(2101, c_stg, 8'h7, "s2_rise");
    expect_at(3100, c_stg, 8'h7, "s3_pre");
    expect_at(3101, c_stg, 8'hF, "s3_rise");
    expect_at(4009, c_done, 8'h0, "done_pre");
    expect_at(4010, c_done, 8'h1, "done_rise");
    expect_at(4010, c_stg,  8'hF, "late_mask_noeffect");
    expect_at(4010, c_c2h,  c_gated ? 8'h0 : 8'h1, "c2h_at_done");
    expect_at(4011, c_c2h,  8'h1, "c2h_after_done");

    repeat (3) @(negedge usr_clk);
    usr_rst_n = 1'b1;

    wait_to(3500); bus.stg_mask_i = 4'h0;
    wait_to(4020); bus.stg_mask_i = 4'hF;

    // Restart at edge 5000 after done has settled
    expect_at(4999, c_done, 8'h1, "done_hold");
    expect_at(4999, c_stg,  8'hF, "stg_hold");
    expect_at(5000, c_stg,  8'h0, "rst1_stg_clr");
    expect_at(5000, c_done, 8'h0, "rst1_done_clr");
    expect_at(5001, c_c2h,  c_gated ? 8'h0 : 8'h1, "rst1_c2h_gate");
    expect_at(5100, c_stg,  8'h0, "r2_s0_pre");
    expect_at(5101, c_stg,  8'h1, "r2_s0_rise");
    expect_at(6101, c_stg,  8'h1, "r2_s1_masked");
    expect_at(7100, c_stg,  8'h1, "r2_pre_restart");
    expect_at(7101, c_stg,  8'h0, "r2_restart_beats_s2");
    expect_at(7101, c_done, 8'h0, "r2_restart_done");
    wait_to(4999); bus.restart_i = 1'b1;
    wait_to(5000); bus.restart_i = 1'b0;
    wait_to(6090); bus.stg_mask_i = 4'b0101;
    wait_to(6110); bus.stg_mask_i = 4'hF;

    // Second restart lands exactly on stage 2's fire edge
    expect_at(7201,  c_stg,  8'h0, "r3_s0_pre");
    expect_at(7202,  c_stg,  8'h1, "r3_s0_rise");
    expect_at(10202, c_stg,  8'hF, "r3_s3_rise");
    expect_at(11110, c_done, 8'h0, "r3_done_pre");
    expect_at(11111, c_done, 8'h1, "r3_done_rise");
    expect_at(11111, c_c2h,  c_gated ? 8'h0 : 8'h1, "r3_c2h_at_done");
    expect_at(11112, c_c2h,  8'h1, "r3_c2h_after");
    expect_at(11112, c_h2c,  8'h3, "r3_h2c_after");
    wait_to(7100); bus.restart_i = 1'b1;
    wait_to(7101); bus.restart_i = 1'b0;

    wait_to(11120);
    expect_at(11200, c_lp,  8'h0, "lp_pre");
    expect_at(11201, c_lp,  8'h1, "lp_enter");
    expect_at(11201, c_h2c, 8'h3, "h2c_still_on");
    expect_at(11202, c_h2c, 8'h2, "h2c_drop_ch1_kept");
    expect_at(11202, c2h_sel(), 8'h0, "c2h_drop");
    expect_at(11229, c_h2c, 8'h2, "quiesce_last");
    expect_at(11230, c_h2c, 8'h3, "quiesce_end");
    expect_at(11230, c_c2h, 8'h1, "quiesce_end_c2h");
    expect_at(11230, c_lp,  8'h0, "lp_left");
    expect_at(11251, c_h2c, 8'h2, "h2c_req_off");
    expect_at(11261, c_h2c, 8'h3, "h2c_req_on");
    expect_at(11301, c_lp,  8'h1, "lp_enter2");
    expect_at(11311, c_lp,  8'h0, "lp_leave2");
    expect_at(11317, c_lp,  8'h1, "lp_toggle_q3");
    expect_at(11318, c_lp,  8'h0, "lp_toggle_back");
    expect_at(11320, c_h2c, 8'h2, "reload_no_early");
    expect_at(11326, c_h2c, 8'h2, "reload_last");
    expect_at(11327, c_h2c, 8'h3, "reload_end");
    expect_at(11327, c_c2h, 8'h1, "reload_end_c2h");

    wait_to(11200); bus.lp_md_i   = 4'b0011;
    wait_to(11220); bus.lp_md_i   = 4'b0000;
    wait_to(11250); bus.h2c_run_i = 2'b10;
    wait_to(11260); bus.h2c_run_i = 2'b11;
    wait_to(11300); bus.lp_md_i   = 4'b0011;
    wait_to(11310); bus.lp_md_i   = 4'b0000;
    wait_to(11316); bus.lp_md_i   = 4'b0011;
    wait_to(11317); bus.lp_md_i   = 4'b0000;

    wait_to(11340);
    done_stim = 1'b1;
    repeat (2) @(negedge usr_clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  function automatic int c2h_sel();
    return c_c2h;
  endfunction

endmodule
`default_nettype wire
